down_counter_reload: RTL and testbench
======================================

Name: down_counter_reload

Overview:
- Synchronous loadable N-bit down counter with borrow-out for cascading and optional auto-reload. It is the count-down companion to the team's loadable up counter.
- Used as a programmable divider or timer: load a period, count down to zero, then either wrap to all-ones or reload the period.
- Built from the shared JK flip-flop cell, one cell per bit, in the same style as the up counter.

Parameters:
WIDTH, 4, counter width in bits (legal range 2..16)

Ports:
clk        input   1      system clock; all state updates on the rising edge
clear      input   1      asynchronous, active-low reset
load       input   1      synchronous parallel load of i into a and into the reload register
count      input   1      count enable; decrement when high and load is low
auto       input   1      auto-reload mode select
i          input   WIDTH  parallel load value
a          output  WIDTH  current count
bout       output  1      borrow-out: combinational, high when a == 0 (not gated by count)
expire     output  1      registered one-cycle pulse on each zero-crossing event

Behaviour:
- Reset (clear low, asynchronous, independent of clk):
  - a = 0, reload register r = 0, expire = 0.
  - Outputs hold while clear is low. The first rising edge after clear deasserts follows normal rules.
- Per rising edge, priority load > count > hold:
  - load=1: a <= i, r <= i, expire <= 0. count and auto are ignored.
  - load=0, count=1, a != 0: a <= a - 1, expire <= 0.
  - load=0, count=1, a == 0, auto=0: a <= all-ones (modulo-2^WIDTH wrap), expire <= 1.
  - load=0, count=1, a == 0, auto=1: a <= r, expire <= 1. If r == 0, a stays 0 and expire fires every enabled cycle (divide-by-1).
  - load=0, count=0: a and r hold, expire <= 0.
- Latency:
  - a reflects load or decrement one cycle after the qualifying edge.
  - bout is combinational from a, with zero latency.
  - expire is high for exactly the cycle after a zero-crossing event.
- Arithmetic: unsigned, modulo 2^WIDTH. No saturation.
- Period: with auto=1 and loaded value P, expire fires every P+1 enabled cycles.
- Cascading: the enable of the next stage is count & bout of this stage. bout of the whole chain is the AND of all stage bouts.
- Simultaneous load and count at a == 0: load wins, no expire.
- auto is sampled only on the zero-crossing edge and may change at any time without side effects.
- Reset during counting: immediate a = 0 and r = 0. A pending expire is dropped.
- Per-bit JK drive, with dec = count & ~load & (a != 0) & AND of lower bits all zero:
  - Bit k toggles (J = K = 1) when dec holds. Bit 0 toggles when count & ~load & (a != 0).
  - Load path: J = load & i[k], K = load & ~i[k].
  - Zero-crossing path:
    - wrap: J = 1.
    - reload: J = r[k], K = ~r[k].

Decomposition:
- Shared include header: WIDTH default constant, ZERO and ALL_ONES constant macros.
- Sub-module: reuse the existing jk cell (clk, clear, j, k, out), whose clear is asynchronous active-low; one instance per bit of a.
- The reload register r and the expire flop use the existing dfr cell.
- Next-state J/K logic stays inline in down_counter_reload.

Test Plan:
- Reset: clear low mid-count at a=9 -> a=0, expire=0, bout=1 immediately, without a clock edge.
- Load/decrement (WIDTH=4): load i=3, then count=1 for 4 cycles ->
  - a = 3, 2, 1, 0, 15.
  - bout high only while a=0.
  - expire high on the cycle a=15 appears.
- Auto-reload: load 2, auto=1, count=1 continuously -> a = 2, 1, 0, 2, 1, 0, 2; expire pulses every 3rd cycle.
- Priority and hold:
  - a=0, load=1 with i=5 and count=1 -> a=5, no expire.
  - count=0 for 3 cycles -> a holds at 5.
- Cascade: two 4-bit instances, stage-2 count = count & bout1, both loaded 0x10 -> combined value decrements 0x10, 0x0F, ...; combined bout high only at 0x00.
- Reload-zero corner: load 0, auto=1, count=1 -> a stays 0, expire high every enabled cycle.

Source files
------------

// File: rtl/down_counter_reload_pkg.sv
// Shared definitions for the reloadable down counter and its cells.
package down_counter_reload_pkg;

  localparam int unsigned DEFAULT_WIDTH = 4;

  // JK input pairs, encoded as {j, k}.
  typedef enum logic [1:0] {
    JK_HOLD   = 2'b00,
    JK_RESET  = 2'b01,
    JK_SET    = 2'b10,
    JK_TOGGLE = 2'b11
  } jk_op_e;

  function automatic jk_op_e jk_force(input logic value);
    if (value) begin
      return JK_SET;
    end else begin
      return JK_RESET;
    end
  endfunction

endpackage

// File: rtl/down_counter_reload_dfr.sv
// D flip-flop cell with asynchronous active-low clear, parameterised width.
module down_counter_reload_dfr #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         clear,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] q_q;

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      q_q <= '0;
    end else begin
      q_q <= d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/down_counter_reload_jk.sv
// Single-bit JK flip-flop cell with asynchronous active-low clear.
module down_counter_reload_jk
  import down_counter_reload_pkg::*;
(
  input  logic clk,
  input  logic clear,
  input  logic j,
  input  logic k,
  output logic out
);

  logic out_q;
  logic out_d;

  always_comb begin
    out_d = out_q;
    case (jk_op_e'({j, k}))
      JK_HOLD:   out_d = out_q;
      JK_RESET:  out_d = 1'b0;
      JK_SET:    out_d = 1'b1;
      JK_TOGGLE: out_d = ~out_q;
      default:   out_d = out_q;
    endcase
  end

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      out_q <= 1'b0;
    end else begin
      out_q <= out_d;
    end
  end

  assign out = out_q;

endmodule

// File: rtl/down_counter_reload.sv
// Loadable down counter built from JK cells, with borrow-out, wrap or
// auto-reload at zero, and a registered expire pulse on each zero crossing.
module down_counter_reload
  import down_counter_reload_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             load,
  input  logic             count,
  input  logic             auto,
  input  logic [WIDTH-1:0] i,
  output logic [WIDTH-1:0] a,
  output logic             bout,
  output logic             expire
);

  localparam logic [WIDTH-1:0] ZERO     = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_d;
  logic             expire_q;
  logic             expire_d;
  logic [WIDTH-1:0] j_s;
  logic [WIDTH-1:0] k_s;
  logic [WIDTH-1:0] lower_zero_s;
  logic             a_zero_s;
  jk_op_e           op_s;

  assign a_zero_s = (a_q == ZERO);

  // Per-bit JK drive: load, then ripple-borrow decrement, then zero crossing.
  always_comb begin
    j_s          = ZERO;
    k_s          = ZERO;
    lower_zero_s = ZERO;
    op_s         = JK_HOLD;
    for (int b = 0; b < int'(WIDTH); b++) begin
      if (b == 0) begin
        lower_zero_s[b] = 1'b1;
      end else begin
        lower_zero_s[b] = lower_zero_s[b-1] & ~a_q[b-1];
      end
      if (load) begin
        op_s = jk_force(i[b]);
      end else if (count && !a_zero_s) begin
        op_s = lower_zero_s[b] ? JK_TOGGLE : JK_HOLD;
      end else if (count) begin
        // a is zero here: wrap sets every bit, reload copies r.
        op_s = auto ? jk_force(r_q[b]) : jk_force(ALL_ONES[b]);
      end else begin
        op_s = JK_HOLD;
      end
      j_s[b] = op_s[1];
      k_s[b] = op_s[0];
    end
  end

  // Reload register capture and zero-crossing detection.
  always_comb begin
    r_d      = r_q;
    expire_d = 1'b0;
    if (load) begin
      r_d      = i;
      expire_d = 1'b0;
    end else begin
      r_d      = r_q;
      expire_d = count & a_zero_s;
    end
  end

  genvar gb;
  generate
    for (gb = 0; gb < int'(WIDTH); gb++) begin : g_bit
      down_counter_reload_jk u_jk (
        .clk   (clk),
        .clear (clear),
        .j     (j_s[gb]),
        .k     (k_s[gb]),
        .out   (a_q[gb])
      );
    end
  endgenerate

  down_counter_reload_dfr #(.W(WIDTH)) u_reload (
    .clk   (clk),
    .clear (clear),
    .d     (r_d),
    .q     (r_q)
  );

  down_counter_reload_dfr #(.W(1)) u_expire (
    .clk   (clk),
    .clear (clear),
    .d     (expire_d),
    .q     (expire_q)
  );

  assign a      = a_q;
  assign bout   = a_zero_s;
  assign expire = expire_q;

endmodule

// File: tb/tb_down_counter_reload.sv
// Directed bench for down_counter_reload: single 4-bit instance plus a
// two-stage cascade, checked against hand-computed values.
module tb_down_counter_reload;

  logic       clk;
  logic       clear;
  logic       load;
  logic       count;
  logic       auto;
  logic [3:0] i;
  logic [3:0] a;
  logic       bout;
  logic       expire;

  logic       c_load;
  logic       c_count;
  logic [3:0] c1_a;
  logic [3:0] c2_a;
  logic       c1_bout;
  logic       c2_bout;
  logic       c1_expire;
  logic       c2_expire;
  logic       c2_count;

  int n_vec;
  int n_miss;

  down_counter_reload #(.WIDTH(4)) dut (
    .clk(clk), .clear(clear), .load(load), .count(count), .auto(auto),
    .i(i), .a(a), .bout(bout), .expire(expire)
  );

  assign c2_count = c_count & c1_bout;

  down_counter_reload #(.WIDTH(4)) u_c1 (
    .clk(clk), .clear(clear), .load(c_load), .count(c_count), .auto(1'b0),
    .i(4'h0), .a(c1_a), .bout(c1_bout), .expire(c1_expire)
  );

  down_counter_reload #(.WIDTH(4)) u_c2 (
    .clk(clk), .clear(clear), .load(c_load), .count(c2_count), .auto(1'b0),
    .i(4'h1), .a(c2_a), .bout(c2_bout), .expire(c2_expire)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    n_vec++;
    assert (obs === exp_v) else begin
      n_miss++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk3(input string tag, input logic [3:0] ea, input logic eb, input logic ee);
    check({tag, ".a"}, {12'h000, a}, {12'h000, ea});
    check({tag, ".bout"}, {15'h0000, bout}, {15'h0000, eb});
    check({tag, ".expire"}, {15'h0000, expire}, {15'h0000, ee});
  endtask

  initial begin
    logic [7:0] exp_c;
    n_vec   = 0;
    n_miss  = 0;
    clear   = 1'b0;
    load    = 1'b0;
    count   = 1'b0;
    auto    = 1'b0;
    i       = 4'h0;
    c_load  = 1'b0;
    c_count = 1'b0;
    #3;
    chk3("reset", 4'h0, 1'b1, 1'b0);
    #4;
    clear = 1'b1;

    // Asynchronous clear mid-count at a=9.
    load = 1'b1; i = 4'hA;
    step();
    chk3("ld10", 4'hA, 1'b0, 1'b0);
    load = 1'b0; count = 1'b1;
    step();
    chk3("dec9", 4'h9, 1'b0, 1'b0);
    #2; clear = 1'b0; #1;
    chk3("clr_mid", 4'h0, 1'b1, 1'b0);
    clear = 1'b1; count = 1'b0;

    // Load 3, count down through zero and wrap.
    load = 1'b1; i = 4'h3;
    step();
    chk3("ld3", 4'h3, 1'b0, 1'b0);
    load = 1'b0; count = 1'b1;
    step(); chk3("d2", 4'h2, 1'b0, 1'b0);
    step(); chk3("d1", 4'h1, 1'b0, 1'b0);
    step(); chk3("d0", 4'h0, 1'b1, 1'b0);
    step(); chk3("wrap", 4'hF, 1'b0, 1'b1);
    step(); chk3("d14", 4'hE, 1'b0, 1'b0);

    // Auto-reload with period 3.
    load = 1'b1; i = 4'h2; auto = 1'b1;
    step(); chk3("ar_ld", 4'h2, 1'b0, 1'b0);
    load = 1'b0;
    step(); chk3("ar1", 4'h1, 1'b0, 1'b0);
    step(); chk3("ar0", 4'h0, 1'b1, 1'b0);
    step(); chk3("ar_rl", 4'h2, 1'b0, 1'b1);
    step(); chk3("ar1b", 4'h1, 1'b0, 1'b0);
    step(); chk3("ar0b", 4'h0, 1'b1, 1'b0);
    step(); chk3("ar_rl2", 4'h2, 1'b0, 1'b1);

    // Load beats count at zero; then hold.
    step(); step();
    chk3("pr_zero", 4'h0, 1'b1, 1'b0);
    load = 1'b1; i = 4'h5;
    step(); chk3("pr_ld", 4'h5, 1'b0, 1'b0);
    load = 1'b0; count = 1'b0;
    for (int n = 0; n < 3; n++) begin
      step(); chk3("hold", 4'h5, 1'b0, 1'b0);
    end

    // Reload of zero: divide-by-1.
    load = 1'b1; i = 4'h0; count = 1'b1;
    step(); chk3("rz_ld", 4'h0, 1'b1, 1'b0);
    load = 1'b0;
    for (int n = 0; n < 3; n++) begin
      step(); chk3("rz", 4'h0, 1'b1, 1'b1);
    end
    count = 1'b0;
    step(); chk3("rz_off", 4'h0, 1'b1, 1'b0);

    // Clear drops a pending expire pulse.
    auto = 1'b0; count = 1'b1;
    step(); chk3("wrap2", 4'hF, 1'b0, 1'b1);
    #2; clear = 1'b0; #1;
    chk3("clr_exp", 4'h0, 1'b1, 1'b0);
    clear = 1'b1; count = 1'b0;

    // Two-stage cascade loaded with 0x10.
    c_load = 1'b1;
    step();
    c_load = 1'b0; c_count = 1'b1;
    exp_c = 8'h10;
    check("casc_ld", {8'h00, c2_a, c1_a}, {8'h00, exp_c});
    for (int n = 0; n < 18; n++) begin
      step();
      exp_c = exp_c - 8'h01;
      check("casc_a", {8'h00, c2_a, c1_a}, {8'h00, exp_c});
      check("casc_bout", {15'h0000, c1_bout & c2_bout}, {15'h0000, exp_c == 8'h00});
    end
    c_count = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
